// File: rtl/priority_encoder_reg_if.sv
// Request/index bundle for priority_encoder_reg: capture inputs, the valid/ready index stream and
// the pending-vector view. master = encoder side, slave = source/consumer side.
interface priority_encoder_reg_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
);
  logic         en;
  logic [N-1:0] in;
  logic [W-1:0] out;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] pending;

  modport master (
    input  en,
    input  in,
    input  out_ready,
    output out,
    output out_valid,
    output pending
  );

  modport slave (
    output en,
    output in,
    output out_ready,
    input  out,
    input  out_valid,
    input  pending
  );
endinterface

// File: rtl/priority_encoder_reg.sv
// Registered N-to-W priority encoder with sticky request buffering and a valid/ready index output.
// Define ROUND_ROBIN_EN for rotating priority; the default build uses fixed highest-index-wins.
module priority_encoder_reg #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input logic                   clk,
  input logic                   rst,
  priority_encoder_reg_if.master bus
);

  typedef enum logic [0:0] {StIdle, StValid} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] out_q, out_d;
  logic [N-1:0] served;
  logic [N-1:0] remain;
  logic         fire;
  logic         load;
  logic [W-1:0] sel_idx;
  logic         sel_hit;

  assign bus.out       = out_q;
  assign bus.out_valid = (state_q == StValid);
  assign bus.pending   = pend_q;

  assign fire   = bus.out_valid & bus.out_ready;
  assign served = fire ? (N'(1) << out_q) : '0;
  // In IDLE nothing is served, so remain == pend_q and one selector covers both states.
  assign remain = pend_q & ~served;
  assign pend_d = remain | (bus.en ? bus.in : '0);

`ifdef ROUND_ROBIN_EN
  logic [W-1:0] ptr_q, ptr_d;

  // Search starts just above the last loaded index and wraps upward.
  always_comb begin
    sel_idx = '0;
    sel_hit = 1'b0;
    for (int k = 1; k <= int'(N); k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= int'(N)) j = j - int'(N);
      if (!sel_hit && remain[j]) begin
        sel_idx = W'(j);
        sel_hit = 1'b1;
      end
    end
  end

  assign ptr_d = load ? sel_idx : ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= W'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Later iterations overwrite earlier ones, so the highest set index wins.
  always_comb begin
    sel_idx = '0;
    sel_hit = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (remain[i]) begin
        sel_idx = W'(i);
        sel_hit = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sel_hit) begin
          load    = 1'b1;
          state_d = StValid;
        end
      end
      StValid: begin
        if (fire) begin
          if (sel_hit) begin
            load = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (load) out_d = sel_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pend_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
    end
  end

endmodule
